mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, single system clock, rising-edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL have port opcode, input, 6, IR[31:26] from the instruction register.
REQ-004 SHALL have port func, input, 6, IR[5:0] from the instruction register.
REQ-005 SHALL have port cmp_true, input, 1, comparator result for beq, valid in EXEC.
REQ-006 SHALL have ports im_ack and dm_ack, input, 1 each, memory-done handshakes.
REQ-007 SHALL have ports im_req and dm_req, output, 1 each, memory request strobes.
REQ-008 SHALL have ports ir_wr_en, pc_wr_en, rf_wr_en and dm_wr_en, output, 1 each, datapath write enables.
REQ-009 SHALL have ports npc_op (4), alu_op (4), alu_b_sel (2), rf_wr_sel (3), rf_wd_sel (3), ext_op (1) and cmp_op (4), output, datapath selects using the shared const.v encodings.
REQ-010 SHALL have port state, output, 3, current FSM state.
REQ-011 SHALL have ports retire, output, 1, one-cycle pulse per completed instruction, and retire_cnt, output, 32, running count.

Function
REQ-012 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; codes 5-7 SHALL go to FETCH on the next clock.
REQ-013 In FETCH: SHALL assert im_req; on im_ack SHALL assert ir_wr_en and pc_wr_en with npc_op=PC4 and go to DECODE; otherwise SHALL hold FETCH.
REQ-014 In DECODE with jal: SHALL assert pc_wr_en (npc_op=JAL) and rf_wr_en (rf_wr_sel=31, rf_wd_sel=PC, which already holds PC+4), then go to FETCH.
REQ-015 In DECODE with jr: SHALL assert pc_wr_en with npc_op=JR, then go to FETCH.
REQ-016 In DECODE with an unrecognised opcode/func: SHALL treat it as a nop, with no enables asserted, and go to FETCH.
REQ-017 In DECODE with any other instruction: SHALL go to EXEC.
REQ-018 In EXEC: add/sub/ori/lui SHALL go to WB; lw/sw SHALL go to MEM.
REQ-019 In EXEC with beq: SHALL assert pc_wr_en = cmp_true with npc_op=BR, then go to FETCH.
REQ-020 In MEM: SHALL assert dm_req, plus dm_wr_en for sw only.
REQ-021 In MEM on dm_ack: sw SHALL go to FETCH and lw SHALL go to WB; without dm_ack SHALL hold MEM with outputs unchanged.
REQ-022 In WB: SHALL assert rf_wr_en for exactly one cycle, then go to FETCH.
  - add/sub: rf_wr_sel=rd, rf_wd_sel=ALU.
  - ori/lui: rf_wr_sel=rt, rf_wd_sel=ALU.
  - lw: rf_wr_sel=rt, rf_wd_sel=DMRD.
REQ-023 Select outputs SHALL be decoded combinationally from opcode/func in every state; enables and strobes SHALL be asserted only in the states listed above.
REQ-024 Latency with immediate acks: jal/jr/nop 2 cycles, beq 3, sw 4, R-type/ori/lui 4, lw 5; each wait cycle on im_ack/dm_ack adds 1.
REQ-025 retire SHALL pulse in the cycle the FSM leaves DECODE, EXEC, MEM or WB for FETCH; retire_cnt SHALL increment on that same edge and wrap from 0xFFFFFFFF to 0.
REQ-026 An ack arriving outside the matching state SHALL be ignored.

Reset
REQ-027 While reset is high: state SHALL be FETCH, retire_cnt SHALL be 0, and all enables, strobes and retire SHALL be 0.
REQ-028 A reset asserted mid-instruction SHALL abandon that instruction without a write in the reset cycle and without a retire count.

Structure
REQ-029 State codes, NPCOp, ALUOp, select and CMPOp encodings SHALL live in the shared const.v macro file.
REQ-030 A single combinational sub-module mc_decode SHALL map opcode/func to instruction class and select outputs; mc_ctrl SHALL own the state register, transitions and counter.

Verification
REQ-031 Scenario: reset for 2 cycles, then release -> state=0, im_req=1, retire_cnt=0.
REQ-032 Scenario: add with im_ack held 1 -> states 0,1,2,4,0; rf_wr_en high only in WB with rf_wr_sel=rd; retire pulse; retire_cnt=1.
REQ-033 Scenario: lw with dm_ack delayed 3 cycles -> MEM held 4 cycles, dm_wr_en=0 throughout, then WB with rf_wd_sel=DMRD; 8 cycles total.
REQ-034 Scenario: beq with cmp_true=0, then beq with cmp_true=1 -> pc_wr_en low in the first EXEC and high in the second with npc_op=BR; 3 cycles each.
REQ-035 Scenario: jal, then opcode 0x3F -> jal writes reg 31 in DECODE; 0x3F causes no enables; retire_cnt advances by 2.
REQ-036 Scenario: reset asserted in MEM of sw -> dm_wr_en=0 that cycle, state=0 next cycle, retire_cnt=0.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: FSM states, instruction classes,
// opcode/func values and the datapath select codes.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StMem    = 3'd3,
        StWb     = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        ClsNop,
        ClsAlu,
        ClsImm,
        ClsLw,
        ClsSw,
        ClsBeq,
        ClsJal,
        ClsJr
    } instr_cls_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpOri   = 6'h0d;
    localparam logic [5:0] OpLui   = 6'h0f;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2b;

    localparam logic [5:0] FnJr  = 6'h08;
    localparam logic [5:0] FnAdd = 6'h20;
    localparam logic [5:0] FnSub = 6'h22;

    localparam logic [3:0] NpcPc4 = 4'd0;
    localparam logic [3:0] NpcBr  = 4'd1;
    localparam logic [3:0] NpcJal = 4'd2;
    localparam logic [3:0] NpcJr  = 4'd3;

    localparam logic [3:0] AluAdd = 4'd0;
    localparam logic [3:0] AluSub = 4'd1;
    localparam logic [3:0] AluOr  = 4'd2;
    localparam logic [3:0] AluLui = 4'd3;

    localparam logic [1:0] AluBRt  = 2'd0;
    localparam logic [1:0] AluBImm = 2'd1;

    localparam logic [2:0] RfWrRd = 3'd0;
    localparam logic [2:0] RfWrRt = 3'd1;
    localparam logic [2:0] RfWr31 = 3'd2;

    localparam logic [2:0] RfWdAlu  = 3'd0;
    localparam logic [2:0] RfWdDmrd = 3'd1;
    localparam logic [2:0] RfWdPc   = 3'd2;

    localparam logic ExtZero = 1'b0;
    localparam logic ExtSign = 1'b1;

    localparam logic [3:0] CmpEq = 4'd0;

    // An instruction completes whenever a working state hands control back to FETCH.
    function automatic logic retires(state_e from, state_e to);
        return (from inside {StDecode, StExec, StMem, StWb}) && (to == StFetch);
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath/memory bundle; the controller drives the master side.
interface mc_ctrl_if;
    logic [5:0]  opcode;
    logic [5:0]  func;
    logic        cmp_true;
    logic        im_ack;
    logic        dm_ack;
    logic        im_req;
    logic        dm_req;
    logic        ir_wr_en;
    logic        pc_wr_en;
    logic        rf_wr_en;
    logic        dm_wr_en;
    logic [3:0]  npc_op;
    logic [3:0]  alu_op;
    logic [1:0]  alu_b_sel;
    logic [2:0]  rf_wr_sel;
    logic [2:0]  rf_wd_sel;
    logic        ext_op;
    logic [3:0]  cmp_op;
    logic [2:0]  state;
    logic        retire;
    logic [31:0] retire_cnt;

    modport master (
        input  opcode, func, cmp_true, im_ack, dm_ack,
        output im_req, dm_req, ir_wr_en, pc_wr_en, rf_wr_en, dm_wr_en,
        output npc_op, alu_op, alu_b_sel, rf_wr_sel, rf_wd_sel, ext_op, cmp_op,
        output state, retire, retire_cnt
    );

    modport slave (
        output opcode, func, cmp_true, im_ack, dm_ack,
        input  im_req, dm_req, ir_wr_en, pc_wr_en, rf_wr_en, dm_wr_en,
        input  npc_op, alu_op, alu_b_sel, rf_wr_sel, rf_wd_sel, ext_op, cmp_op,
        input  state, retire, retire_cnt
    );
endinterface

// File: rtl/mc_decode.sv
// Combinational instruction decoder: opcode/func to instruction class and datapath selects.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0]  opcode_i,
    input  logic [5:0]  func_i,
    output instr_cls_e  cls_o,
    output logic [3:0]  npc_op_o,
    output logic [3:0]  alu_op_o,
    output logic [1:0]  alu_b_sel_o,
    output logic [2:0]  rf_wr_sel_o,
    output logic [2:0]  rf_wd_sel_o,
    output logic        ext_op_o,
    output logic [3:0]  cmp_op_o
);

    always_comb begin
        cls_o       = ClsNop;
        npc_op_o    = NpcPc4;
        alu_op_o    = AluAdd;
        alu_b_sel_o = AluBRt;
        rf_wr_sel_o = RfWrRd;
        rf_wd_sel_o = RfWdAlu;
        ext_op_o    = ExtSign;
        cmp_op_o    = CmpEq;
        case (opcode_i)
            OpRtype: begin
                case (func_i)
                    FnAdd: cls_o = ClsAlu;
                    FnSub: begin
                        cls_o    = ClsAlu;
                        alu_op_o = AluSub;
                    end
                    FnJr: begin
                        cls_o    = ClsJr;
                        npc_op_o = NpcJr;
                    end
                    default: cls_o = ClsNop;
                endcase
            end
            OpOri: begin
                cls_o       = ClsImm;
                alu_op_o    = AluOr;
                alu_b_sel_o = AluBImm;
                rf_wr_sel_o = RfWrRt;
                ext_op_o    = ExtZero;
            end
            OpLui: begin
                cls_o       = ClsImm;
                alu_op_o    = AluLui;
                alu_b_sel_o = AluBImm;
                rf_wr_sel_o = RfWrRt;
                ext_op_o    = ExtZero;
            end
            OpLw: begin
                cls_o       = ClsLw;
                alu_b_sel_o = AluBImm;
                rf_wr_sel_o = RfWrRt;
                rf_wd_sel_o = RfWdDmrd;
            end
            OpSw: begin
                cls_o       = ClsSw;
                alu_b_sel_o = AluBImm;
            end
            OpBeq: begin
                cls_o    = ClsBeq;
                alu_op_o = AluSub;
                npc_op_o = NpcBr;
            end
            OpJal: begin
                cls_o       = ClsJal;
                npc_op_o    = NpcJal;
                rf_wr_sel_o = RfWr31;
                rf_wd_sel_o = RfWdPc;
            end
            default: cls_o = ClsNop;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle controller: FETCH/DECODE/EXEC/MEM/WB sequencing, write enables,
// memory strobes and the retired-instruction counter.
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input logic       clk,
    input logic       reset,
    mc_ctrl_if.master bus
);

    state_e      state_q, state_d;
    logic [31:0] retire_cnt_q, retire_cnt_d;
    instr_cls_e  cls;
    logic [3:0]  npc_dec;
    logic [3:0]  alu_op;
    logic [1:0]  alu_b_sel;
    logic [2:0]  rf_wr_sel;
    logic [2:0]  rf_wd_sel;
    logic        ext_op;
    logic [3:0]  cmp_op;
    logic        retire;

    mc_decode u_decode (
        .opcode_i    (bus.opcode),
        .func_i      (bus.func),
        .cls_o       (cls),
        .npc_op_o    (npc_dec),
        .alu_op_o    (alu_op),
        .alu_b_sel_o (alu_b_sel),
        .rf_wr_sel_o (rf_wr_sel),
        .rf_wd_sel_o (rf_wd_sel),
        .ext_op_o    (ext_op),
        .cmp_op_o    (cmp_op)
    );

    assign bus.alu_op     = alu_op;
    assign bus.alu_b_sel  = alu_b_sel;
    assign bus.rf_wr_sel  = rf_wr_sel;
    assign bus.rf_wd_sel  = rf_wd_sel;
    assign bus.ext_op     = ext_op;
    assign bus.cmp_op     = cmp_op;
    // IR still holds the previous instruction in FETCH, so its branch select is overridden.
    assign bus.npc_op     = (state_q == StFetch) ? NpcPc4 : npc_dec;
    assign bus.state      = reset ? StFetch : state_q;
    assign bus.retire_cnt = reset ? 32'd0 : retire_cnt_q;

    always_comb begin
        state_d      = state_q;
        bus.im_req   = 1'b0;
        bus.dm_req   = 1'b0;
        bus.ir_wr_en = 1'b0;
        bus.pc_wr_en = 1'b0;
        bus.rf_wr_en = 1'b0;
        bus.dm_wr_en = 1'b0;
        case (state_q)
            StFetch: begin
                bus.im_req = 1'b1;
                if (bus.im_ack) begin
                    bus.ir_wr_en = 1'b1;
                    bus.pc_wr_en = 1'b1;
                    state_d      = StDecode;
                end
            end
            StDecode: begin
                case (cls)
                    ClsJal: begin
                        bus.pc_wr_en = 1'b1;
                        bus.rf_wr_en = 1'b1;
                        state_d      = StFetch;
                    end
                    ClsJr: begin
                        bus.pc_wr_en = 1'b1;
                        state_d      = StFetch;
                    end
                    ClsNop:  state_d = StFetch;
                    default: state_d = StExec;
                endcase
            end
            StExec: begin
                case (cls)
                    ClsBeq: begin
                        bus.pc_wr_en = bus.cmp_true;
                        state_d      = StFetch;
                    end
                    ClsLw, ClsSw:   state_d = StMem;
                    ClsAlu, ClsImm: state_d = StWb;
                    default:        state_d = StFetch;
                endcase
            end
            StMem: begin
                bus.dm_req   = 1'b1;
                bus.dm_wr_en = (cls == ClsSw);
                if (bus.dm_ack) begin
                    state_d = (cls == ClsLw) ? StWb : StFetch;
                end
            end
            StWb: begin
                bus.rf_wr_en = 1'b1;
                state_d      = StFetch;
            end
            default: state_d = StFetch;
        endcase

        retire = retires(state_q, state_d);

        // Reset abandons the in-flight instruction: no write, strobe or retire this cycle.
        if (reset) begin
            bus.im_req   = 1'b0;
            bus.dm_req   = 1'b0;
            bus.ir_wr_en = 1'b0;
            bus.pc_wr_en = 1'b0;
            bus.rf_wr_en = 1'b0;
            bus.dm_wr_en = 1'b0;
            retire       = 1'b0;
            state_d      = StFetch;
        end
    end

    assign bus.retire = retire;
    assign retire_cnt_d = retire ? retire_cnt_q + 32'd1 : retire_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StFetch;
            retire_cnt_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: each step queues its expected outputs, which are popped and
// compared against the DUT on the following falling edge.
module tb_mc_ctrl;
    import mc_ctrl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mc_ctrl_if bus ();

    mc_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Control vector order: im_req dm_req ir_wr_en pc_wr_en rf_wr_en dm_wr_en retire
    localparam logic [6:0] CIdle     = 7'b0000000;
    localparam logic [6:0] CFetch    = 7'b1000000;
    localparam logic [6:0] CFetchAck = 7'b1011000;
    localparam logic [6:0] CRetire   = 7'b0000001;
    localparam logic [6:0] CJal      = 7'b0001101;
    localparam logic [6:0] CWb       = 7'b0000101;
    localparam logic [6:0] CMemRd    = 7'b0100000;
    localparam logic [6:0] CSwWait   = 7'b0100010;
    localparam logic [6:0] CSwDone   = 7'b0100011;
    localparam logic [6:0] CBrTaken  = 7'b0001001;
    localparam logic [5:0] OpBad     = 6'h3f;

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic [6:0]  ctl;
        logic [31:0] cnt;
        logic [3:0]  npc;
        logic [2:0]  wsel;
        logic [2:0]  wdsel;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] cnt_model = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare();
        exp_t e;
        checks++;
        assert (sb.size() != 0)
        else begin
            errors++;
            $error("FAIL scoreboard: observed=empty expected=entry");
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({e.tag, ".state"}, 32'(bus.state), 32'(e.st));
            chk({e.tag, ".ctl"}, 32'({bus.im_req, bus.dm_req, bus.ir_wr_en, bus.pc_wr_en,
                                     bus.rf_wr_en, bus.dm_wr_en, bus.retire}), 32'(e.ctl));
            chk({e.tag, ".cnt"}, bus.retire_cnt, e.cnt);
            chk({e.tag, ".npc"}, 32'(bus.npc_op), 32'(e.npc));
            if (e.ctl[2]) begin
                chk({e.tag, ".wsel"}, 32'(bus.rf_wr_sel), 32'(e.wsel));
                chk({e.tag, ".wdsel"}, 32'(bus.rf_wd_sel), 32'(e.wdsel));
            end
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic [5:0] op,
                        input logic [5:0] fn, input logic cmp, input logic ia, input logic da,
                        input logic [2:0] st, input logic [6:0] ctl, input logic [3:0] npc,
                        input logic [2:0] wsel, input logic [2:0] wdsel);
        exp_t e;
        reset        = rst;
        bus.opcode   = op;
        bus.func     = fn;
        bus.cmp_true = cmp;
        bus.im_ack   = ia;
        bus.dm_ack   = da;
        e.tag   = tag;
        e.st    = st;
        e.ctl   = ctl;
        e.cnt   = rst ? 32'd0 : cnt_model;
        e.npc   = npc;
        e.wsel  = wsel;
        e.wdsel = wdsel;
        sb.push_back(e);
        if (rst) cnt_model = 32'd0;
        else if (ctl[0]) cnt_model = cnt_model + 32'd1;
        @(negedge clk);
        compare();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        bus.opcode   = OpRtype;
        bus.func     = FnAdd;
        bus.cmp_true = 1'b0;
        bus.im_ack   = 1'b0;
        bus.dm_ack   = 1'b0;
        @(posedge clk);
        #1;
        // Reset, then release with no ack; a stray dm_ack in FETCH is ignored
        step("rst0", 1'b1, OpRtype, FnAdd, 1'b0, 1'b1, 1'b1, StFetch, CIdle, NpcPc4, RfWrRd, RfWdAlu);
        step("rst1", 1'b1, OpRtype, FnAdd, 1'b0, 1'b0, 1'b0, StFetch, CIdle, NpcPc4, RfWrRd, RfWdAlu);
        step("idle", 1'b0, OpRtype, FnAdd, 1'b0, 1'b0, 1'b1, StFetch, CFetch, NpcPc4, RfWrRd, RfWdAlu);
        // add, im_ack held high throughout
        step("add.f", 1'b0, OpRtype, FnAdd, 1'b0, 1'b1, 1'b0, StFetch, CFetchAck, NpcPc4, RfWrRd, RfWdAlu);
        step("add.d", 1'b0, OpRtype, FnAdd, 1'b0, 1'b1, 1'b0, StDecode, CIdle, NpcPc4, RfWrRd, RfWdAlu);
        step("add.e", 1'b0, OpRtype, FnAdd, 1'b0, 1'b1, 1'b1, StExec, CIdle, NpcPc4, RfWrRd, RfWdAlu);
        step("add.w", 1'b0, OpRtype, FnAdd, 1'b0, 1'b1, 1'b0, StWb, CWb, NpcPc4, RfWrRd, RfWdAlu);
        // lw with dm_ack three cycles late
        step("lw.f", 1'b0, OpLw, 6'h00, 1'b0, 1'b1, 1'b0, StFetch, CFetchAck, NpcPc4, RfWrRt, RfWdDmrd);
        step("lw.d", 1'b0, OpLw, 6'h00, 1'b0, 1'b0, 1'b0, StDecode, CIdle, NpcPc4, RfWrRt, RfWdDmrd);
        step("lw.e", 1'b0, OpLw, 6'h00, 1'b0, 1'b0, 1'b0, StExec, CIdle, NpcPc4, RfWrRt, RfWdDmrd);
        step("lw.m0", 1'b0, OpLw, 6'h00, 1'b0, 1'b1, 1'b0, StMem, CMemRd, NpcPc4, RfWrRt, RfWdDmrd);
        step("lw.m1", 1'b0, OpLw, 6'h00, 1'b0, 1'b0, 1'b0, StMem, CMemRd, NpcPc4, RfWrRt, RfWdDmrd);
        step("lw.m2", 1'b0, OpLw, 6'h00, 1'b0, 1'b0, 1'b0, StMem, CMemRd, NpcPc4, RfWrRt, RfWdDmrd);
        step("lw.m3", 1'b0, OpLw, 6'h00, 1'b0, 1'b0, 1'b1, StMem, CMemRd, NpcPc4, RfWrRt, RfWdDmrd);
        step("lw.w", 1'b0, OpLw, 6'h00, 1'b0, 1'b0, 1'b0, StWb, CWb, NpcPc4, RfWrRt, RfWdDmrd);
        // beq not taken, then taken
        step("beq0.f", 1'b0, OpBeq, 6'h00, 1'b0, 1'b1, 1'b0, StFetch, CFetchAck, NpcPc4, RfWrRd, RfWdAlu);
        step("beq0.d", 1'b0, OpBeq, 6'h00, 1'b1, 1'b0, 1'b0, StDecode, CIdle, NpcBr, RfWrRd, RfWdAlu);
        step("beq0.e", 1'b0, OpBeq, 6'h00, 1'b0, 1'b0, 1'b0, StExec, CRetire, NpcBr, RfWrRd, RfWdAlu);
        step("beq1.f", 1'b0, OpBeq, 6'h00, 1'b1, 1'b1, 1'b0, StFetch, CFetchAck, NpcPc4, RfWrRd, RfWdAlu);
        step("beq1.d", 1'b0, OpBeq, 6'h00, 1'b1, 1'b0, 1'b0, StDecode, CIdle, NpcBr, RfWrRd, RfWdAlu);
        step("beq1.e", 1'b0, OpBeq, 6'h00, 1'b1, 1'b0, 1'b0, StExec, CBrTaken, NpcBr, RfWrRd, RfWdAlu);
        // jal after one im_ack wait cycle, then an unrecognised opcode
        step("jal.w", 1'b0, OpJal, 6'h00, 1'b0, 1'b0, 1'b0, StFetch, CFetch, NpcPc4, RfWr31, RfWdPc);
        step("jal.f", 1'b0, OpJal, 6'h00, 1'b0, 1'b1, 1'b0, StFetch, CFetchAck, NpcPc4, RfWr31, RfWdPc);
        step("jal.d", 1'b0, OpJal, 6'h00, 1'b0, 1'b0, 1'b0, StDecode, CJal, NpcJal, RfWr31, RfWdPc);
        step("nop.f", 1'b0, OpBad, 6'h00, 1'b0, 1'b1, 1'b0, StFetch, CFetchAck, NpcPc4, RfWrRd, RfWdAlu);
        step("nop.d", 1'b0, OpBad, 6'h00, 1'b0, 1'b0, 1'b1, StDecode, CRetire, NpcPc4, RfWrRd, RfWdAlu);
        // sw with immediate dm_ack
        step("sw.f", 1'b0, OpSw, 6'h00, 1'b0, 1'b1, 1'b0, StFetch, CFetchAck, NpcPc4, RfWrRd, RfWdAlu);
        step("sw.d", 1'b0, OpSw, 6'h00, 1'b0, 1'b0, 1'b0, StDecode, CIdle, NpcPc4, RfWrRd, RfWdAlu);
        step("sw.e", 1'b0, OpSw, 6'h00, 1'b0, 1'b0, 1'b0, StExec, CIdle, NpcPc4, RfWrRd, RfWdAlu);
        step("sw.m", 1'b0, OpSw, 6'h00, 1'b0, 1'b0, 1'b1, StMem, CSwDone, NpcPc4, RfWrRd, RfWdAlu);
        // sw interrupted by reset while waiting in MEM
        step("sw2.f", 1'b0, OpSw, 6'h00, 1'b0, 1'b1, 1'b0, StFetch, CFetchAck, NpcPc4, RfWrRd, RfWdAlu);
        step("sw2.d", 1'b0, OpSw, 6'h00, 1'b0, 1'b0, 1'b0, StDecode, CIdle, NpcPc4, RfWrRd, RfWdAlu);
        step("sw2.e", 1'b0, OpSw, 6'h00, 1'b0, 1'b0, 1'b0, StExec, CIdle, NpcPc4, RfWrRd, RfWdAlu);
        step("sw2.m", 1'b0, OpSw, 6'h00, 1'b0, 1'b0, 1'b0, StMem, CSwWait, NpcPc4, RfWrRd, RfWdAlu);
        step("sw2.rst", 1'b1, OpSw, 6'h00, 1'b0, 1'b0, 1'b1, StFetch, CIdle, NpcPc4, RfWrRd, RfWdAlu);
        step("post", 1'b0, OpSw, 6'h00, 1'b0, 1'b0, 1'b0, StFetch, CFetch, NpcPc4, RfWrRd, RfWdAlu);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
